// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC sample sequencer.
// Holds the sequencer FSM encoding, the serializer state codes and the default minimum period.
package adc_seq_pkg;

    localparam int MIN_PERIOD_DEF = 20;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        ARM   = 3'd2,
        CONV  = 3'd3,
        DRAIN = 3'd4
    } seq_state_e;

    localparam logic [1:0] SPI_IDLE = 2'd0;
    localparam logic [1:0] SPI_XMIT = 2'd1;
    localparam logic [1:0] SPI_DONE = 2'd2;

endpackage

// File: rtl/adc_sample_sequencer_if.sv
// Handshake between the sequencer (master) and the AD7476 serializer / RX FIFO side (slave).
// Member suffixes are given from the sequencer's point of view.
interface adc_sample_sequencer_if;
    logic       spi_start_o;
    logic       spi_rden_o;
    logic [1:0] spi_fsm_st_i;
    logic       spi_tfer_done_i;
    logic       rx_fifo_full_i;

    modport master (
        output spi_start_o, spi_rden_o,
        input  spi_fsm_st_i, spi_tfer_done_i, rx_fifo_full_i
    );

    modport slave (
        input  spi_start_o, spi_rden_o,
        output spi_fsm_st_i, spi_tfer_done_i, rx_fifo_full_i
    );
endinterface

// File: rtl/adc_seq_period_timer.sv
// Loadable down-counter that paces conversion starts.
// Periods below MIN_PERIOD are clamped; tc_o fires on the zero count and the counter reloads itself.
module adc_seq_period_timer #(
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = 20
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             load_i,
    input  logic             run_i,
    input  logic [CNT_W-1:0] period_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] reload;

    // Reload is eff_period-1 so that a full cycle spans exactly eff_period clocks.
    always_comb begin
        if (period_i < CNT_W'(MIN_PERIOD)) reload = CNT_W'(MIN_PERIOD - 1);
        else                               reload = period_i - 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i)     cnt_q <= '0;
        else if (load_i)  cnt_q <= reload;
        else if (run_i)   cnt_q <= (cnt_q == '0) ? reload : cnt_q - 1'b1;
    end

    assign tc_o = run_i && (cnt_q == '0);

endmodule

// File: rtl/adc_sample_sequencer.sv
// Paces AD7476 conversion starts, gates the serializer read-enable, runs bursts and tracks overruns.
// Optional macro ADC_SEQ_FIRST_DISCARD_EN: discard the first pair after every start of capture.
module adc_sample_sequencer
    import adc_seq_pkg::*;
#(
    parameter int CNT_W      = 16,
    parameter int MIN_PERIOD = MIN_PERIOD_DEF,
    parameter int OVR_W      = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   enable_i,
    input  logic [CNT_W-1:0]       sample_period_i,
    input  logic [CNT_W-1:0]       burst_len_i,
    input  logic                   clr_status_i,
    adc_sample_sequencer_if.master spi,
    output logic                   busy_o,
    output logic                   burst_done_o,
    output logic [CNT_W-1:0]       sample_cnt_o,
    output logic                   overrun_o,
    output logic [OVR_W-1:0]       overrun_cnt_o
);

`ifdef ADC_SEQ_FIRST_DISCARD_EN
    localparam bit FIRST_DISCARD = 1'b1;
`else
    localparam bit FIRST_DISCARD = 1'b0;
`endif

    seq_state_e       state_q, state_d;
    logic             parity_q, parity_d;
    logic             arm_wait_q, arm_wait_d;
    logic             pend_q, pend_d;
    logic             discard_q, discard_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             done_q, done_d;
    logic             ovr_q, ovr_d;
    logic [OVR_W-1:0] ovr_cnt_q, ovr_cnt_d, ovr_base;
    logic             ovr_evt, start, load, tmr_tc, late;

    adc_seq_period_timer #(
        .CNT_W      (CNT_W),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_timer (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .load_i   (load),
        .run_i    (state_q != IDLE),
        .period_i (sample_period_i),
        .tc_o     (tmr_tc)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            parity_q   <= 1'b0;
            arm_wait_q <= 1'b0;
            pend_q     <= 1'b0;
            discard_q  <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            ovr_q      <= 1'b0;
            ovr_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            parity_q   <= parity_d;
            arm_wait_q <= arm_wait_d;
            pend_q     <= pend_d;
            discard_q  <= discard_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            ovr_q      <= ovr_d;
            ovr_cnt_q  <= ovr_cnt_d;
        end
    end

    assign late = (spi.spi_fsm_st_i != SPI_IDLE) || spi.spi_tfer_done_i;

    always_comb begin
        state_d    = state_q;
        parity_d   = parity_q;
        arm_wait_d = arm_wait_q;
        pend_d     = pend_q;
        discard_d  = discard_q;
        cnt_d      = cnt_q;
        done_d     = clr_status_i ? 1'b0 : done_q;
        ovr_evt    = 1'b0;
        start      = 1'b0;
        load       = 1'b0;

        // A tick landing while a start is still outstanding must not be lost.
        if (tmr_tc && (state_q == ARM || state_q == CONV)) pend_d = 1'b1;

        case (state_q)
            IDLE: begin
                parity_d   = 1'b0;
                pend_d     = 1'b0;
                arm_wait_d = 1'b0;
                if (enable_i) begin
                    load      = 1'b1;
                    cnt_d     = '0;
                    done_d    = 1'b0;
                    discard_d = FIRST_DISCARD;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (!enable_i) state_d = IDLE;
                else if (tmr_tc || pend_q) begin
                    pend_d     = 1'b0;
                    arm_wait_d = 1'b0;
                    state_d    = ARM;
                end
            end
            ARM: begin
                if (!enable_i) state_d = IDLE;
                else if (!parity_q && spi.rx_fifo_full_i) begin
                    ovr_evt = 1'b1;
                    state_d = WAIT;
                end else begin
                    arm_wait_d = 1'b1;
                    if (late && !arm_wait_q) ovr_evt = 1'b1;
                    if (spi.spi_fsm_st_i == SPI_IDLE) begin
                        start   = 1'b1;
                        state_d = CONV;
                    end
                end
            end
            CONV: begin
                if (spi.spi_fsm_st_i == SPI_DONE) begin
                    parity_d = ~parity_q;
                    state_d  = enable_i ? WAIT : IDLE;
                    if (parity_q) begin
                        if (discard_q) discard_d = 1'b0;
                        else begin
                            cnt_d = cnt_q + 1'b1;
                            if (burst_len_i != '0 && cnt_d >= burst_len_i) begin
                                done_d  = 1'b1;
                                state_d = DRAIN;
                            end
                        end
                    end
                end
            end
            DRAIN:   state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new event beats a coincident clear.
        ovr_base  = clr_status_i ? '0 : ovr_cnt_q;
        ovr_cnt_d = ovr_base;
        ovr_d     = clr_status_i ? 1'b0 : ovr_q;
        if (ovr_evt) begin
            ovr_d = 1'b1;
            if (ovr_base != '1) ovr_cnt_d = ovr_base + 1'b1;
        end
    end

    assign spi.spi_start_o = start;
    assign spi.spi_rden_o  = (state_q != IDLE) && !discard_q;
    assign busy_o          = (state_q != IDLE);
    assign burst_done_o    = done_q;
    assign sample_cnt_o    = cnt_q;
    assign overrun_o       = ovr_q;
    assign overrun_cnt_o   = ovr_cnt_q;

endmodule

// File: doc/adc_sample_sequencer.md
Name: adc_sample_sequencer

Overview:
- Upstream control stage for the AD7476 SPI serializer/deserializer.
- Generates paced conversion-start strobes at a programmable sample period and gates the serializer's read-enable.
- Runs fixed-length bursts or continuous capture, and drops sample pairs when the downstream RX FIFO is full.
- Reports busy, burst-done, sample count and overrun status to the register block.

Parameters:
- CNT_W, 16, width of period and burst counters.
- MIN_PERIOD, 20, minimum clocks between starts: 16 data bits plus start and done overhead, plus margin.
- OVR_W, 8, width of the saturating overrun counter.

Ports:
- clk_i  in  1  serializer clock; one clock domain only.
- rst_n_i  in  1  asynchronous active-low reset.
- enable_i  in  1  capture enable, level.
- sample_period_i  in  CNT_W  clocks between start strobes; values below MIN_PERIOD are treated as MIN_PERIOD.
- burst_len_i  in  CNT_W  number of 32-bit sample pairs per burst; 0 = continuous.
- clr_status_i  in  1  pulse; clears overrun_o, overrun_cnt_o and burst_done_o.
- spi_fsm_st_i  in  2  serializer FSM state: 0 idle, 1 transmit, 2 done.
- spi_tfer_done_i  in  1  serializer last-bit indication.
- rx_fifo_full_i  in  1  downstream FIFO full.
- spi_start_o  out  1  one-cycle start strobe to the serializer.
- spi_rden_o  out  1  read-enable to the serializer; its pair-toggle is cleared while this is low.
- busy_o  out  1  sequencer is not in IDLE.
- burst_done_o  out  1  sticky; set when a finite burst completes.
- sample_cnt_o  out  CNT_W  pairs captured in the current burst.
- overrun_o  out  1  sticky; set on any dropped pair or late start.
- overrun_cnt_o  out  OVR_W  saturating count of drop events.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; period timer 0; pair parity 0.
- FSM states and transitions:
  - IDLE: if enable_i=1, clear sample_cnt_o and burst_done_o, load timer with eff_period-1, go to WAIT. Here eff_period = max(sample_period_i, MIN_PERIOD).
  - WAIT: decrement timer. At timer=0, reload timer and go to ARM.
  - ARM, parity=0 (first sample of a pair):
    - if rx_fifo_full_i=1, drop the whole pair: overrun event, stay pair-aligned, return to WAIT with no strobe;
    - otherwise, if spi_fsm_st_i=0, assert spi_start_o for one cycle and go to CONV.
  - ARM, parity=1 (second sample): no FIFO check; strobe when spi_fsm_st_i=0.
  - ARM, serializer not idle: hold in ARM and record an overrun event once, on the first waiting cycle only.
  - CONV: wait for spi_fsm_st_i=2, then toggle parity.
    - If the pair just completed (parity was 1), increment sample_cnt_o.
    - If burst_len_i!=0 and sample_cnt_o reaches burst_len_i, set burst_done_o and go to DRAIN.
    - Otherwise go to WAIT.
  - DRAIN: hold spi_rden_o=1 for one extra clock so the serializer's final push completes, then go to IDLE.
- The timer free-runs during ARM and CONV, so the start cadence is exact whenever the period is at least the transfer time.
- spi_rden_o = 1 in WAIT, ARM, CONV and DRAIN; 0 in IDLE.
- The serializer pushes on the done cycle of every second transfer: the first push 18 clocks after the second strobe.
- enable_i deasserted mid-burst:
  - finish any transfer in CONV;
  - if parity=1, abandon the half pair;
  - return to IDLE with spi_rden_o=0 so the serializer's pair-toggle resets;
  - burst_done_o is not set.
- Asynchronous reset mid-transfer: everything returns to reset values immediately. The serializer is reset by the same source.
- overrun_cnt_o saturates at all ones. overrun_o is set on every event, including while the count is saturated.
- Simultaneous clr_status_i and a new overrun event: the event wins, giving overrun_o=1 and overrun_cnt_o=1.
- sample_period_i and burst_len_i are sampled at every timer reload and burst-end compare; changing them mid-burst takes effect at the next reload.
- spi_tfer_done_i is used only for the overrun check: a start requested during a transfer's last bit counts as late.

Optional Feature:
- Macro: ADC_SEQ_FIRST_DISCARD_EN.
- Defined:
  - after each IDLE->WAIT, the first pair is converted with spi_rden_o=0, so the serializer does not push; this discards the AD7476 power-up conversion;
  - the discarded pair is not counted in sample_cnt_o;
  - spi_rden_o rises at the start of the second pair;
  - sample_cnt_o and burst_done_o timing is unchanged, apart from the extra pair of latency.
- Undefined: the first pair is captured normally.

Decomposition:
- Package adc_seq_pkg:
  - FSM state encoding IDLE=0, WAIT=1, ARM=2, CONV=3, DRAIN=4;
  - the serializer state constants SPI_IDLE=0, SPI_XMIT=1, SPI_DONE=2;
  - the MIN_PERIOD default.
- One natural sub-module, adc_seq_period_timer: a loadable down-counter with clamp and terminal-count strobe.

Test Plan:
- Period 100, burst 4, FIFO never full -> 8 strobes spaced exactly 100 clocks; 4 pushes from the serializer; sample_cnt_o=4; burst_done_o=1; return to IDLE.
- Period 5 -> clamped to a 20-clock spacing; no overrun.
- rx_fifo_full_i high during the 2nd pair's first ARM, burst 3 -> that pair is skipped; overrun_o=1; overrun_cnt_o=1; 3 pairs still captured (burst length counts captured pairs).
- enable_i dropped one clock after the 3rd strobe, burst 0 -> the transfer completes; 1 push total; spi_rden_o=0; busy_o=0; a restart captures correctly aligned pairs.
- 300 forced overruns -> overrun_cnt_o=255; a clr_status_i pulse gives 0; clr_status_i coincident with an event gives 1.
- ADC_SEQ_FIRST_DISCARD_EN defined, burst 2 -> 6 strobes, 2 pushes, spi_rden_o low for the first 2 strobes.
